// File: rtl/pcie_trans_gen.sv
// rtl/pcie_trans_gen.sv - main FIFO -> VC FIFOs -> arbiter -> destination FIFOs transaction switch
// Optional PCIE_TRANS_RR_ARB_EN selects round-robin VC arbitration instead of strict priority.

module pcie_trans_gen_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, do_pop, do_push;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module pcie_trans_gen #(
    parameter int DATA_W   = 6,
    parameter int VC_CNT   = 2,
    parameter int DST_CNT  = 2,
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int D_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic                        init,
    input  logic [$clog2(MF_DEPTH):0]   umbral_mf,
    input  logic [$clog2(VC_DEPTH):0]   umbral_vc,
    input  logic [$clog2(D_DEPTH):0]    umbral_d,
    input  logic                        push,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [DST_CNT-1:0]          pop_out,
    output logic [DST_CNT*DATA_W-1:0]   data_out,
    output logic [DST_CNT-1:0]          valid_out,
    output logic                        pause_mf,
    output logic                        active_out,
    output logic                        idle_out,
    output logic                        error_out,
    output logic [VC_CNT+DST_CNT:0]     error_full
);
    localparam int VC_W  = $clog2(VC_CNT);
    localparam int DST_W = $clog2(DST_CNT);
    localparam int MF_AW = $clog2(MF_DEPTH);
    localparam int VC_AW = $clog2(VC_DEPTH);
    localparam int D_AW  = $clog2(D_DEPTH);

    typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
    state_t state, next_state;

    logic [DATA_W-1:0]  mf_head;
    logic [MF_AW:0]     mf_count;
    logic               mf_pop, mf_ovf;
    logic [DATA_W-1:0]  vc_head [VC_CNT];
    logic [VC_AW:0]     vc_count [VC_CNT];
    logic [VC_CNT-1:0]  vc_push, vc_pop, vc_ovf, vc_nonempty, vc_pause;
    logic [DATA_W-1:0]  d_head [DST_CNT];
    logic [D_AW:0]      d_count [DST_CNT];
    logic [DST_CNT-1:0] d_push, d_ovf, d_pause;
    logic [MF_AW:0]     th_mf;
    logic [VC_AW:0]     th_vc;
    logic [D_AW:0]      th_d;
    logic               sa_valid, sb_valid, gnt_valid, found, busy;
    logic [DATA_W-1:0]  sa_data, sb_data;
    logic [VC_W-1:0]    gnt_idx;
`ifdef PCIE_TRANS_RR_ARB_EN
    logic [VC_W-1:0]    rr_ptr, cand;
`endif

    pcie_trans_gen_fifo #(.DEPTH(MF_DEPTH), .W(DATA_W)) u_mf (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(mf_pop), .din(data_in),
        .head(mf_head), .count(mf_count), .overflow(mf_ovf)
    );

    assign mf_pop   = (mf_count != '0) && !(|vc_pause);
    assign pause_mf = (mf_count >= th_mf);

    for (genvar v = 0; v < VC_CNT; v++) begin : g_vc
        assign vc_push[v]     = sa_valid && (sa_data[DATA_W-1 -: VC_W] == VC_W'(v));
        assign vc_pop[v]      = gnt_valid && (gnt_idx == VC_W'(v));
        assign vc_nonempty[v] = (vc_count[v] != '0);
        assign vc_pause[v]    = (vc_count[v] >= th_vc);
        pcie_trans_gen_fifo #(.DEPTH(VC_DEPTH), .W(DATA_W)) u_vc (
            .clk(clk), .reset_L(reset_L), .push(vc_push[v]), .pop(vc_pop[v]), .din(sa_data),
            .head(vc_head[v]), .count(vc_count[v]), .overflow(vc_ovf[v])
        );
    end

    for (genvar d = 0; d < DST_CNT; d++) begin : g_dst
        assign d_push[d]    = sb_valid && (sb_data[DATA_W-1-VC_W -: DST_W] == DST_W'(d));
        assign d_pause[d]   = (d_count[d] >= th_d);
        assign valid_out[d] = (d_count[d] != '0);
        pcie_trans_gen_fifo #(.DEPTH(D_DEPTH), .W(DATA_W)) u_dst (
            .clk(clk), .reset_L(reset_L), .push(d_push[d]), .pop(pop_out[d]), .din(sb_data),
            .head(d_head[d]), .count(d_count[d]), .overflow(d_ovf[d])
        );
        assign data_out[d*DATA_W +: DATA_W] = d_head[d];
    end

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
`ifdef PCIE_TRANS_RR_ARB_EN
        cand = '0;
        for (int i = 0; i < VC_CNT; i++) begin
            cand = rr_ptr + VC_W'(i + 1);
            if (!found && vc_nonempty[cand]) begin
                gnt_idx = cand;
                found   = 1'b1;
            end
        end
`else
        for (int i = VC_CNT - 1; i >= 0; i--) begin
            if (vc_nonempty[i]) gnt_idx = VC_W'(i);
        end
        found = |vc_nonempty;
`endif
        gnt_valid = found && !(|d_pause);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sa_valid   <= 1'b0;
            sa_data    <= '0;
            sb_valid   <= 1'b0;
            sb_data    <= '0;
            th_mf      <= (MF_AW+1)'(MF_DEPTH - 1);
            th_vc      <= (VC_AW+1)'(VC_DEPTH - 1);
            th_d       <= (D_AW+1)'(D_DEPTH - 1);
            error_full <= '0;
`ifdef PCIE_TRANS_RR_ARB_EN
            rr_ptr     <= VC_W'(VC_CNT - 1);
`endif
        end else begin
            sa_valid   <= mf_pop;
            sa_data    <= mf_head;
            sb_valid   <= gnt_valid;
            sb_data    <= vc_head[gnt_idx];
            error_full <= error_full | {d_ovf, vc_ovf, mf_ovf};
            // A zero threshold would pause permanently, so it keeps the old value.
            if (state == S_INIT) begin
                if (umbral_mf != '0) th_mf <= umbral_mf;
                if (umbral_vc != '0) th_vc <= umbral_vc;
                if (umbral_d != '0)  th_d  <= umbral_d;
            end
`ifdef PCIE_TRANS_RR_ARB_EN
            if (gnt_valid) rr_ptr <= gnt_idx;
`endif
        end
    end

    assign busy = (mf_count != '0) || (|vc_nonempty) || (|valid_out) || sa_valid || sb_valid;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= S_RESET;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_INIT;
            S_INIT:   if (!init) next_state = S_IDLE;
            S_IDLE:   if (init) next_state = S_INIT; else if (busy) next_state = S_ACTIVE;
            S_ACTIVE: if (init) next_state = S_INIT; else if (!busy) next_state = S_IDLE;
            default:  next_state = S_ERROR;
        endcase
        if (state != S_RESET && (|error_full)) next_state = S_ERROR;
    end

    always_comb begin
        idle_out   = (state == S_IDLE);
        active_out = (state == S_ACTIVE);
        error_out  = (state == S_ERROR);
    end
endmodule

// File: tb/tb_pcie_trans_gen.sv
// tb/tb_pcie_trans_gen.sv - directed self-checking bench for pcie_trans_gen
module tb_pcie_trans_gen;
    logic        clk = 1'b0;
    logic        reset_L, init, push;
    logic [2:0]  umbral_mf, umbral_d;
    logic [4:0]  umbral_vc;
    logic [5:0]  data_in;
    logic [1:0]  pop_out;
    logic [11:0] data_out;
    logic [1:0]  valid_out;
    logic        pause_mf, active_out, idle_out, error_out;
    logic [4:0]  error_full;

    logic        w_push;
    logic [2:0]  w_umbral_mf, w_umbral_d;
    logic [4:0]  w_umbral_vc;
    logic [7:0]  w_data_in;
    logic [3:0]  w_pop_out;
    logic [31:0] w_data_out;
    logic [3:0]  w_valid_out;
    logic        w_pause_mf, w_active_out, w_idle_out, w_error_out;
    logic [8:0]  w_error_full;

    int          checks = 0;
    int          errors = 0;
    int          got;
    logic [5:0]  arb_exp [8];

    always #5 clk = ~clk;

    pcie_trans_gen dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_mf(umbral_mf), .umbral_vc(umbral_vc), .umbral_d(umbral_d),
        .push(push), .data_in(data_in), .pop_out(pop_out),
        .data_out(data_out), .valid_out(valid_out), .pause_mf(pause_mf),
        .active_out(active_out), .idle_out(idle_out), .error_out(error_out),
        .error_full(error_full)
    );

    pcie_trans_gen #(.DATA_W(8), .VC_CNT(4), .DST_CNT(4)) dut_wide (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_mf(w_umbral_mf), .umbral_vc(w_umbral_vc), .umbral_d(w_umbral_d),
        .push(w_push), .data_in(w_data_in), .pop_out(w_pop_out),
        .data_out(w_data_out), .valid_out(w_valid_out), .pause_mf(w_pause_mf),
        .active_out(w_active_out), .idle_out(w_idle_out), .error_out(w_error_out),
        .error_full(w_error_full)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
`ifdef PCIE_TRANS_RR_ARB_EN
        arb_exp = '{6'h10, 6'h30, 6'h11, 6'h31, 6'h12, 6'h32, 6'h13, 6'h33};
`else
        arb_exp = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h30, 6'h31, 6'h32, 6'h33};
`endif
        reset_L = 1'b0; init = 1'b0; push = 1'b0; data_in = '0; pop_out = '0;
        umbral_mf = '0; umbral_vc = '0; umbral_d = '0;
        w_push = 1'b0; w_data_in = '0; w_pop_out = '0;
        w_umbral_mf = '0; w_umbral_vc = '0; w_umbral_d = '0;
        cycles(2);
        check("rst_valid", valid_out, 2'b00);
        check("rst_data", data_out, 12'h000);
        check("rst_flags", {active_out, idle_out, error_out, pause_mf}, 4'b0000);
        check("rst_err", error_full, 5'b00000);
        check("rst_w_valid", w_valid_out, 4'b0000);

        // Reset release and INIT with umbral_vc=4
        reset_L = 1'b1; init = 1'b1; umbral_vc = 5'd4;
        cycles(1);
        check("init_flags", {active_out, idle_out, error_out}, 3'b000);
        cycles(1);
        init = 1'b0;
        cycles(1);
        check("init_to_idle", {active_out, idle_out, error_out}, 3'b010);
        umbral_vc = '0;

        // Basic routing: 6'h25 = VC1, dst0, visible after edge N+4
        push = 1'b1; data_in = 6'h25;
        cycles(1);
        push = 1'b0;
        cycles(3);
        check("lat_n3", valid_out, 2'b00);
        check("active", active_out, 1'b1);
        cycles(1);
        check("lat_n4", valid_out, 2'b01);
        check("route_data", data_out[5:0], 6'h25);
        pop_out = 2'b01;
        cycles(1);
        pop_out = 2'b00;
        check("pop_empty", valid_out, 2'b00);
        cycles(1);
        check("back_idle", idle_out, 1'b1);

        // Backpressure: umbral_d=2, 11 words to dst1 through VC0
        init = 1'b1; umbral_d = 3'd2;
        cycles(2);
        init = 1'b0;
        cycles(1);
        umbral_d = '0;
        for (int i = 0; i < 11; i++) begin
            push = 1'b1; data_in = 6'h10 + 6'(i);
            cycles(1);
            if (i == 9) check("pause_mf_below", pause_mf, 1'b0);
        end
        push = 1'b0;
        check("pause_mf_at", pause_mf, 1'b1);
        cycles(4);
        check("bp_valid", valid_out, 2'b10);
        check("bp_head", data_out[11:6], 6'h10);
        check("bp_hold", pause_mf, 1'b1);
        check("bp_noerr", error_full, 5'b00000);
        pop_out = 2'b10;
        got = 0;
        for (int c = 0; c < 80 && got < 11; c++) begin
            if (valid_out[1]) begin
                check("bp_order", data_out[11:6], 6'h10 + 6'(got));
                got++;
            end
            cycles(1);
        end
        pop_out = 2'b00;
        check("bp_count", got, 11);
        cycles(3);
        check("bp_idle", idle_out, 1'b1);

        // Arbitration: three VC1 blockers pause dst0, then VC0/VC1 words for dst1
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; data_in = 6'h20 + 6'(i);
            cycles(1);
        end
        for (int k = 0; k < 4; k++) begin
            push = 1'b1; data_in = 6'h10 + 6'(k);
            cycles(1);
            data_in = 6'h30 + 6'(k);
            cycles(1);
        end
        push = 1'b0;
        cycles(8);
        check("arb_blocked", valid_out, 2'b01);
        pop_out = 2'b11;
        got = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            if (valid_out[1]) begin
                check("arb_order", data_out[11:6], arb_exp[got]);
                got++;
            end
            cycles(1);
        end
        pop_out = 2'b00;
        check("arb_count", got, 8);
        cycles(4);
        check("arb_idle", idle_out, 1'b1);

        // Overflow: umbral_vc=1, umbral_d=1 stalls everything, then overfill MF
        init = 1'b1; umbral_vc = 5'd1; umbral_d = 3'd1;
        cycles(2);
        init = 1'b0;
        cycles(1);
        umbral_vc = '0; umbral_d = '0;
        push = 1'b1; data_in = 6'h00;
        cycles(1);
        push = 1'b0;
        cycles(8);
        push = 1'b1; data_in = 6'h01;
        cycles(1);
        push = 1'b0;
        cycles(8);
        check("ovf_pre_valid", valid_out, 2'b01);
        check("ovf_pre_mf", pause_mf, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data_in = 6'h02 + 6'(i);
            cycles(1);
            if (i == 3) begin
                check("ovf_full_noerr", error_full, 5'b00000);
                check("ovf_pause", pause_mf, 1'b1);
            end
        end
        push = 1'b0;
        check("ovf_bit", error_full, 5'b00001);
        check("ovf_flag_lag", error_out, 1'b0);
        cycles(1);
        check("ovf_err_state", error_out, 1'b1);
        init = 1'b1;
        cycles(2);
        check("err_hold_init", {active_out, idle_out, error_out}, 3'b001);
        init = 1'b0;
        #2 reset_L = 1'b0;
        #1;
        check("rst_clear_err", error_full, 5'b00000);
        check("rst_clear_flags", {active_out, idle_out, error_out, pause_mf}, 4'b0000);
        check("rst_clear_valid", valid_out, 2'b00);
        @(negedge clk);
        reset_L = 1'b1;
        cycles(2);

        // Width scaling: 8'b11_10_0001 = VC3, dst2
        w_push = 1'b1; w_data_in = 8'hE1;
        cycles(1);
        w_push = 1'b0;
        cycles(3);
        check("w_lat3", w_valid_out, 4'b0000);
        cycles(1);
        check("w_valid", w_valid_out, 4'b0100);
        check("w_data", w_data_out[23:16], 8'hE1);
        check("w_other", {w_data_out[31:24], w_data_out[15:0]}, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
